// File: rtl/message_schedule.sv
// SHA-256 message schedule: takes one 512-bit chunk, streams W[0..ROUNDS-1] from a 16-word window.
// Latency: W[0] appears one cycle after the chunk accept edge, then one word per handshake.
// Backpressure: a stalled word (w_valid && !w_ready) holds every register, so the outputs stay stable.
module message_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [511:0] chunk,
    input  logic         chunk_valid,
    output logic         chunk_ready,
    output logic [31:0]  w_out,
    output logic [5:0]   w_index,
    output logic         w_last,
    output logic         w_valid,
    input  logic         w_ready
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] win [16];
    logic [5:0]  t;
    logic        accept;
    logic        advance;
    logic [31:0] win_new;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    // win[i] holds W[t+i], so the next word entering the window is W[t+16].
    assign win_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    assign w_out   = win[0];
    assign w_index = t;

    always_comb begin
        state_nxt   = state;
        chunk_ready = (state == IDLE);
        w_valid     = (state == STREAM);
        w_last      = (state == STREAM) && (t == LAST_T);
        accept      = chunk_valid && (state == IDLE);
        advance     = (state == STREAM) && w_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (advance && w_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            t     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= 32'd0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                t <= 6'd0;
                for (int i = 0; i < 16; i++) begin
                    win[i] <= chunk[511 - 32*i -: 32];
                end
            end else if (advance) begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15] <= win_new;
                // Hold t on the final word so a 64-round build never wraps the 6-bit index.
                if (!w_last) begin
                    t <= t + 6'd1;
                end
            end
        end
    end

endmodule

// File: doc/message_schedule.md
Name: message_schedule

Overview:
- Sits between `preprocessor` and `chunk_inner_loop` inside `sha256`.
- Accepts one 512-bit padded chunk over a valid/ready handshake.
- Streams the SHA-256 message schedule W[0..ROUNDS-1] one 32-bit word per handshake.
- Keeps only a 16-word sliding window, so the compression loop never stores or expands the chunk itself.

Parameters:
- ROUNDS, 64, number of schedule words emitted per chunk. Legal range 16..64. Production value is 64; smaller values are for reduced-round debug.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- chunk  input  512  padded message block; bits [511:480] are W[0], bits [31:0] are W[15] (big-endian word order).
- chunk_valid  input  1  chunk is presented.
- chunk_ready  output  1  block can accept a chunk this cycle.
- w_out  output  32  current schedule word W[w_index].
- w_index  output  6  round index t of w_out.
- w_last  output  1  high when w_valid and w_index == ROUNDS-1.
- w_valid  output  1  w_out, w_index and w_last are valid.
- w_ready  input  1  consumer takes the word this cycle.

Behaviour:
- State machine:
  - States: IDLE, STREAM.
  - chunk_ready = (state == IDLE).
  - w_valid = (state == STREAM).
  - w_last = w_valid && (t == ROUNDS-1).
- Reset (synchronous, active-high):
  - state = IDLE, t = 0, all 16 window words = 0.
  - Values visible after the reset edge: chunk_ready = 1, w_valid = 0, w_out = 0, w_index = 0, w_last = 0.
  - Reset wins over any simultaneous handshake.
  - Reset during STREAM abandons the chunk with no further words; the next chunk starts at t = 0.
- IDLE to STREAM:
  - Trigger: a rising edge with chunk_valid && chunk_ready.
  - On that edge: win[i] = chunk[511-32i -: 32] for i = 0..15, t = 0, state = STREAM.
  - W[0] appears on w_out in the next cycle (1-cycle latency).
- Outputs in STREAM:
  - w_out = win[0] and w_index = t, both driven directly from registers.
  - chunk_ready = 0 throughout, so no second chunk is accepted while streaming.
- Word handshake (w_valid && w_ready at an edge):
  - win[i] = win[i+1] for i = 0..14.
  - win[15] = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed modulo 2^32 with carries discarded.
  - t = t + 1.
  - Whenever t >= 16, win[0] equals W[t].
- Sigma functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
  - ROTR is a 32-bit rotate right; SHR is a logical shift right.
- Backpressure:
  - While w_valid && !w_ready, all registers hold.
  - w_out, w_index and w_last must stay stable until the handshake.
- Last word:
  - A handshake with w_last set moves the block to IDLE.
  - chunk_ready = 1 on the following cycle.
  - chunk_valid held high during the last-word handshake is not accepted on that edge; it is accepted on the next edge.
- Throughput:
  - With w_ready held at 1, one word is emitted per cycle.
  - A chunk occupies ROUNDS+1 cycles from accept edge to the next accept edge (65 cycles for ROUNDS = 64).
- Counter width: t is 6 bits and never wraps, since ROUNDS-1 <= 63.
- chunk_valid asserted in STREAM is ignored and leaves no side effects.

Test Plan:
- "abc" chunk, w_ready = 1:
  - Stimulus: 0x61626380, then 14 × 0x00000000, then 0x00000018.
  - Required: W[0] = 0x61626380, W[15] = 0x00000018, W[16] = 0x61626380, W[17] = 0x000F0000.
  - All 64 words match the software model; w_last is asserted only at w_index = 63.
  - chunk_ready rises one cycle after the w_last handshake.
- All-zero chunk: all 64 words are 0x00000000; exactly 64 w_valid handshakes.
- Pseudo-random w_ready (about 50% duty) on the "abc" chunk:
  - The word sequence is identical to the first scenario.
  - w_out and w_index are stable during every stall cycle.
- Second chunk held valid throughout the first chunk's stream:
  - chunk_ready = 0 for the whole stream.
  - The second chunk is accepted on the edge after the w_last handshake.
  - Its W[0] appears on the following cycle with w_index = 0.
- Reset asserted at w_index = 20:
  - The next cycle shows w_valid = 0 and chunk_ready = 1.
  - A re-sent "abc" chunk streams from W[0] = 0x61626380 with no residue from the aborted chunk.
- ROUNDS = 16 build:
  - Exactly 16 words, equal to the chunk words.
  - w_last is asserted at w_index = 15.
